// File: rtl/bytewrite_ram_pkg.sv
// Shared types and helpers for the byte-writable data RAM.
// Optional range checking is enabled with BYTEWRITE_RAM_RANGE_CHECK_EN.
package bytewrite_ram_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_WORDS  = 1024;
  localparam int NUM_LANES      = DEF_DATA_WIDTH / 8;
  localparam int IDX_WIDTH      = $clog2(DEF_MEM_WORDS);

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [NUM_LANES-1:0]      be_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [IDX_WIDTH-1:0]      idx_t;

  // Byte offset bits are dropped; upper bits wrap.
  function automatic idx_t word_index(input addr_t a);
    return a[IDX_WIDTH+1:2];
  endfunction

endpackage

// File: rtl/bytewrite_ram_lane.sv
// One 8-bit lane of the data RAM.
// Synchronous read-first storage, no reset on the array.
module bytewrite_ram_lane #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bytewrite_ram.sv
// Single-port data RAM with per-byte write enables, 1-cycle read.
// Define BYTEWRITE_RAM_RANGE_CHECK_EN to add err_o and out-of-range trapping.
module bytewrite_ram
  import bytewrite_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
  output logic                    err_o,
`endif
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(MEM_WORDS);

  logic [IW-1:0]         idx;
  logic                  oor;
  logic                  lane_en;
  logic [DATA_WIDTH-1:0] q;
  logic                  zero_q;
  logic                  unused_addr;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((1 << IW) != MEM_WORDS) begin : g_bad_depth
    $error("MEM_WORDS must be a power of two");
  end

  if (ADDR_WIDTH == DEF_ADDR_WIDTH &&
      MEM_WORDS == DEF_MEM_WORDS) begin : g_idx_pkg
    assign idx = word_index(addr_i);
  end else begin : g_idx_par
    assign idx = addr_i[IW+1:2];
  end

`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
  assign oor         = |addr_i[ADDR_WIDTH-1:IW+2];
  assign unused_addr = ^addr_i[1:0];
`else
  assign oor         = 1'b0;
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:IW+2],
                         addr_i[1:0]};
`endif

  // Out-of-range accesses touch no lane at all.
  assign lane_en = en_i & ~oor;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bytewrite_ram_lane #(
      .DEPTH(MEM_WORDS)
    ) u_lane (
      .clk  (clk_i),
      .en   (lane_en),
      .we   (we_i[k]),
      .addr (idx),
      .wdata(wdata_i[8*k +: 8]),
      .rdata(q[8*k +: 8])
    );
  end

  // Lane outputs have no reset; zero_q masks them after reset or a trap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      zero_q   <= 1'b1;
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
      err_o    <= 1'b0;
`endif
    end else begin
      rvalid_o <= en_i;
      if (en_i) begin
        zero_q <= oor;
      end
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
      err_o    <= en_i & oor;
`endif
    end
  end

  assign rdata_o = zero_q ? '0 : q;

endmodule

// File: tb/tb_bytewrite_ram.sv
// Self-checking bench for bytewrite_ram against a byte-array model.
// Honours BYTEWRITE_RAM_RANGE_CHECK_EN when defined.
module tb_bytewrite_ram;
  import bytewrite_ram_pkg::*;

  localparam int MW = DEF_MEM_WORDS;
  localparam int MEM_BYTES = MW * 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  bytewrite_ram dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    .err_o   (err),
`endif
    .rdata_o (rdata),
    .rvalid_o(rvalid)
  );

`ifndef BYTEWRITE_RAM_RANGE_CHECK_EN
  assign err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mb [MEM_BYTES];
  logic [31:0] exp_rdata;
  logic        exp_valid;
  logic        exp_err;
  int          n_checks;
  int          n_pass;

  function automatic int unsigned base_of(input logic [31:0] a);
    return (a % MEM_BYTES) / 4 * 4;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned b;
    b = base_of(a);
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic bit m_oor(input logic [31:0] a);
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    return a >= MEM_BYTES;
`else
    return (a & 32'd0) != 0;
`endif
  endfunction

  task automatic m_reset();
    exp_rdata = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Model update first (read-first), then one bus cycle.
  task automatic acc(input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    int unsigned b;
    if (e) begin
      exp_valid = 1'b1;
      if (m_oor(a)) begin
        exp_rdata = '0;
        exp_err   = 1'b1;
      end else begin
        exp_rdata = m_read(a);
        exp_err   = 1'b0;
        b = base_of(a);
        for (int k = 0; k < 4; k++)
          if (w[k]) mb[b+k] = d[8*k +: 8];
      end
    end else begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; we = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_reset();
    n_checks++;
    if (rdata !== 32'h0)
      $display("FAIL reset_rdata got %h want %h", rdata, 32'h0);
    else n_pass++;
    n_checks++;
    if (rvalid !== 1'b0)
      $display("FAIL reset_rvalid got %b want 0", rvalid);
    else n_pass++;
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    n_checks++;
    if (err !== 1'b0)
      $display("FAIL reset_err got %b want 0", err);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc(1'b0, 4'h0, 32'h0, 32'h0);
      n_checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0)
        $display("FAIL idle_after_reset got v=%b d=%h want v=0 d=0",
                 rvalid, rdata);
      else n_pass++;
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < MW; i++)
      acc(1'b1, 4'hF, 32'(i * 4), 32'h0);
  endtask

  task automatic test_full_write();
    acc(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    n_checks++;
    if (rvalid !== 1'b1)
      $display("FAIL full_wr_valid got %b want 1", rvalid);
    else n_pass++;
    acc(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks++;
    if (rdata !== 32'hDEADBEEF || rvalid !== 1'b1)
      $display("FAIL full_rd got %h/%b want deadbeef/1", rdata, rvalid);
    else n_pass++;
  endtask

  task automatic test_partial();
    acc(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    acc(1'b1, 4'b0101, 32'h10, 32'h11223344);
    acc(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks++;
    if (rdata !== 32'hDE22BE44)
      $display("FAIL partial got %h want de22be44", rdata);
    else n_pass++;
  endtask

  task automatic test_read_first();
    acc(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5);
    n_checks++;
    if (rdata !== 32'h0)
      $display("FAIL read_first got %h want 0", rdata);
    else n_pass++;
    acc(1'b1, 4'h0, 32'h20, 32'h0);
    n_checks++;
    if (rdata !== 32'hA5A5A5A5)
      $display("FAIL wr_then_rd got %h want a5a5a5a5", rdata);
    else n_pass++;
  endtask

  task automatic test_alias_wrap();
    acc(1'b1, 4'h0, 32'h13, 32'h0);
    n_checks++;
    if (rdata !== 32'hDE22BE44)
      $display("FAIL alias got %h want de22be44", rdata);
    else n_pass++;
`ifndef BYTEWRITE_RAM_RANGE_CHECK_EN
    acc(1'b1, 4'h0, 32'(MEM_BYTES + 32'h10), 32'h0);
    n_checks++;
    if (rdata !== 32'hDE22BE44)
      $display("FAIL wrap got %h want de22be44", rdata);
    else n_pass++;
`endif
  endtask

  task automatic test_idle_hold();
    acc(1'b1, 4'h0, 32'h10, 32'h0);
    for (int i = 0; i < 2; i++) begin
      acc(1'b0, 4'hF, 32'h10, 32'hFFFFFFFF);
      n_checks++;
      if (rvalid !== 1'b0 || rdata !== 32'hDE22BE44)
        $display("FAIL idle_hold got v=%b d=%h want v=0 d=de22be44",
                 rvalid, rdata);
      else n_pass++;
    end
    acc(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks++;
    if (rdata !== 32'hDE22BE44)
      $display("FAIL idle_no_write got %h want de22be44", rdata);
    else n_pass++;
  endtask

`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
  task automatic test_range_check();
    acc(1'b1, 4'hF, 32'(MEM_BYTES), 32'hFFFFFFFF);
    n_checks++;
    if (err !== 1'b1 || rdata !== 32'h0 || rvalid !== 1'b1)
      $display("FAIL oor got e=%b d=%h v=%b want e=1 d=0 v=1",
               err, rdata, rvalid);
    else n_pass++;
    acc(1'b1, 4'h0, 32'h0, 32'h0);
    n_checks++;
    if (err !== 1'b0 || rdata !== 32'h0)
      $display("FAIL oor_word0 got e=%b d=%h want e=0 d=0", err, rdata);
    else n_pass++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] v [8];
    for (int i = 0; i < 8; i++) begin
      v[i] = $urandom;
      acc(1'b1, 4'hF, 32'(32'h100 + i * 4), v[i]);
    end
    for (int i = 0; i < 8; i++) begin
      acc(1'b1, 4'h0, 32'(32'h100 + i * 4), 32'h0);
      n_checks++;
      if (rdata !== v[i] || rvalid !== 1'b1)
        $display("FAIL b2b[%0d] got %h/%b want %h/1", i, rdata, rvalid, v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    acc(1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    en = 1'b1; we = 4'h0; addr = 32'h30;
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (rdata !== 32'h0 || rvalid !== 1'b0)
      $display("FAIL reset_mid got d=%h v=%b want d=0 v=0", rdata, rvalid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    acc(1'b1, 4'h0, 32'h30, 32'h0);
    n_checks++;
    if (rdata !== 32'hCAFEF00D)
      $display("FAIL reset_keeps_mem got %h want cafef00d", rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        e;
    logic [3:0]  w;
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom % 5) != 0;
      w = ($urandom % 2) != 0 ? 4'($urandom) : 4'h0;
      a = ($urandom % 4) == 0 ? $urandom : 32'($urandom_range(0, 255));
      acc(e, w, a, $urandom);
      n_checks++;
      if (rvalid !== exp_valid || rdata !== exp_rdata)
        $display("FAIL rand[%0d] got %h/%b want %h/%b",
                 i, rdata, rvalid, exp_rdata, exp_valid);
      else n_pass++;
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
      if (e) begin
        n_checks++;
        if (err !== exp_err)
          $display("FAIL rand_err[%0d] got %b want %b", i, err, exp_err);
        else n_pass++;
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; en = 1'b0; we = '0; addr = '0; wdata = '0;
    test_reset();
    init_mem();
    test_full_write();
    test_partial();
    test_read_first();
    test_alias_wrap();
    test_idle_hold();
`ifdef BYTEWRITE_RAM_RANGE_CHECK_EN
    test_range_check();
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
